// File: rtl/reg_file.sv
// Two-read/one-write register file with write-through bypass
// and a pending-write scoreboard that drives the issue stall.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              stall
);

  localparam int N = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [N];
  logic [N-1:0]      r_pend;

  logic w_wr;
  logic w_iss;
  logic w_hit1;
  logic w_hit2;
  logic w_st1;
  logic w_st2;

  assign w_wr   = we && (wa != '0);
  assign w_hit1 = w_wr && (wa == ra1);
  assign w_hit2 = w_wr && (wa == ra2);
  assign w_iss  = issue_valid && !stall
               && (issue_rd != '0);

  // Zero-latency reads: x0 is hardwired, same-cycle write wins.
  always_comb begin
    rd1 = r_regs[ra1];
    rd2 = r_regs[ra2];
    if (w_hit1)     rd1 = wd;
    if (ra1 == '0)  rd1 = '0;
    if (w_hit2)     rd2 = wd;
    if (ra2 == '0)  rd2 = '0;
  end

  // A source stalls only if pending and not being written now.
  always_comb begin
    w_st1 = (ra1 != '0) && r_pend[ra1]
         && !(we && (wa == ra1));
    w_st2 = (ra2 != '0) && r_pend[ra2]
         && !(we && (wa == ra2));
    stall = w_st1 || w_st2;
  end

  // Register storage; writes to x0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr) begin
      r_regs[wa] <= wd;
    end
  end

  // Scoreboard: write-back clears, issue sets; set is last so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      if (w_wr)  r_pend[wa]       <= 1'b0;
      if (w_iss) r_pend[issue_rd] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Randomized + directed bench for reg_file against
// an array-based model of register contents and pending bits.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] ra1, ra2, wa, issue_rd;
  logic [DW-1:0] rd1, rd2, wd;
  logic          we, issue_valid, stall;

  reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .stall(stall)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] m_regs [N];
  bit            m_pend [N];
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  tag, obs, exp);
  endtask

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] m_rd(
    input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic bit m_src_stall(
    input logic [AW-1:0] a);
    return a != 0 && m_pend[a] && !(we && wa == a);
  endfunction

  function automatic bit m_stall();
    return m_src_stall(ra1) || m_src_stall(ra2);
  endfunction

  // Check current outputs, cross one rising edge,
  // apply the spec rules to the model, land on negedge.
  task automatic step(input string tag);
    bit s;
    #1;
    s = m_stall();
    chk({tag, ".rd1"}, rd1, m_rd(ra1));
    chk({tag, ".rd2"}, rd2, m_rd(ra2));
    chk({tag, ".stall"}, stall, s);
    @(posedge clk);
    if (rst_n) begin
      if (we && wa != 0) begin
        m_regs[wa] = wd;
        m_pend[wa] = 1'b0;
      end
      if (issue_valid && !s && issue_rd != 0)
        m_pend[issue_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; wa = 0; wd = 0;
    issue_valid = 0; issue_rd = 0;
    ra1 = 0; ra2 = 0;
  endtask

  initial begin
    m_clear();
    idle();
    rst_n = 0;
    @(negedge clk);
    step("rst");
    step("rst");
    chk("rst.rd1", rd1, 0);
    chk("rst.stall", stall, 0);
    rst_n = 1;

    for (int i = 0; i < N; i++) begin
      ra1 = i[AW-1:0];
      ra2 = 5'(N - 1 - i);
      step("rd0");
    end

    we = 1; wa = 5; wd = 32'h1234ABCD; ra1 = 5;
    #1 chk("byp.rd1", rd1, 32'h1234ABCD);
    step("byp");
    we = 0;
    #1 chk("hold.rd1", rd1, 32'h1234ABCD);
    step("hold");

    we = 1; wa = 0; wd = '1; ra2 = 0;
    #1 chk("x0w.rd2", rd2, 0);
    step("x0w");
    we = 0;
    #1 chk("x0r.rd2", rd2, 0);
    step("x0r");

    idle();
    issue_valid = 1; issue_rd = 7;
    step("iss7");
    issue_valid = 0; ra1 = 7;
    #1 chk("pend7.stall", stall, 1);
    step("pend7");
    we = 1; wa = 7; wd = 32'h77;
    #1 chk("wb7.stall", stall, 0);
    step("wb7");
    we = 0;
    #1 chk("done7.stall", stall, 0);
    step("done7");

    idle();
    issue_valid = 1; issue_rd = 9;
    step("iss9");
    we = 1; wa = 9; wd = 32'h99;
    issue_valid = 1; issue_rd = 9;
    step("setclr9");
    idle(); ra2 = 9;
    #1 chk("win9.stall", stall, 1);
    step("win9");
    we = 1; wa = 9; ra2 = 0;
    step("wb9");

    idle();
    we = 1; wa = 3; wd = 32'hA5A5A5A5;
    issue_valid = 1; issue_rd = 4;
    step("pre36");
    idle(); ra1 = 3; ra2 = 4;
    #1 chk("pre36.rd1", rd1, 32'hA5A5A5A5);
    chk("pre36.stall", stall, 1);
    rst_n = 0;
    #1 chk("arst.rd1", rd1, 0);
    chk("arst.stall", stall, 0);
    m_clear();
    rst_n = 1;
    step("post36");

    idle();
    rst_n = 0;
    we = 1; wa = 6; wd = 32'h66;
    issue_valid = 1; issue_rd = 6;
    step("rstwr");
    rst_n = 1;
    idle(); ra1 = 6;
    #1 chk("rstwr.rd1", rd1, 0);
    chk("rstwr.stall", stall, 0);
    step("rstwr2");

    for (int c = 0; c < 600; c++) begin
      ra1 = 5'($urandom_range(0, 7));
      ra2 = 5'($urandom_range(0, 7));
      we = ($urandom_range(0, 2) == 0);
      wa = 5'($urandom_range(0, 7));
      wd = $urandom;
      issue_valid = ($urandom_range(0, 1) == 0);
      issue_rd = 5'($urandom_range(0, 7));
      step("rnd");
    end

    idle();
    for (int i = 0; i < N; i++) begin
      ra1 = i[AW-1:0];
      ra2 = i[AW-1:0];
      step("final");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
